serial_bit_feeder: RTL and testbench

SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

---
 rtl/serial_bit_feeder.sv | 150 +++++++++++++++
 tb/tb_serial_bit_feeder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Accepts parallel words through a one-entry hold register and serializes
// them MSB first onto bit_out. An optional fixed number of idle cycles can
// follow each word. bit_out is forced to 0 whenever no data bit is being sent,
// so a downstream sequence detector only ever sees zeros between words.
module serial_bit_feeder #(
  parameter int DATA_W = 8,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic [7:0]        sent_cnt
);

  localparam int                CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam bit                HAS_GAP  = (GAP > 0);
  // Gap counter preload; the GAP state runs from GAP-1 down to 0.
  localparam logic [3:0]        GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [3:0]          r_gap_cnt;
  logic [7:0]          r_sent_cnt;

  state_t              w_state_next;
  logic [DATA_W-1:0]   w_hold_next;
  logic                w_hold_full_next;
  logic [DATA_W-1:0]   w_shift_next;
  logic [CNT_W-1:0]    w_bit_cnt_next;
  logic [3:0]          w_gap_cnt_next;
  logic [7:0]          w_sent_cnt_next;
  logic                w_load;
  logic                w_accept;

  // The hold register is the only buffer: ready exactly when it is empty.
  assign in_ready = !r_hold_full;
  assign w_accept = in_valid && !r_hold_full;
  assign sent_cnt = r_sent_cnt;

  // State register; asynchronous reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_sent_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_hold      <= w_hold_next;
      r_hold_full <= w_hold_full_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_sent_cnt  <= w_sent_cnt_next;
    end
  end

  // Next-state and output decode for the IDLE / SHIFT / GAP sequencer.
  always_comb begin
    w_state_next     = r_state;
    w_hold_next      = r_hold;
    w_hold_full_next = r_hold_full;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_gap_cnt_next   = r_gap_cnt;
    w_sent_cnt_next  = r_sent_cnt;
    w_load           = 1'b0;
    bit_out          = 1'b0;
    bit_valid        = 1'b0;
    frame_start      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end

      ST_SHIFT: begin
        bit_out        = r_shift[DATA_W-1];
        bit_valid      = 1'b1;
        frame_start    = (r_bit_cnt == '0);
        w_shift_next   = r_shift << 1;
        w_bit_cnt_next = r_bit_cnt + 1'b1;
        if (r_bit_cnt == LAST_BIT) begin
          w_sent_cnt_next = r_sent_cnt + 8'd1;
          if (!HAS_GAP && r_hold_full) begin
            // Back-to-back: next word follows with no bubble.
            w_load = 1'b1;
          end else if (HAS_GAP) begin
            w_state_next   = ST_GAP;
            w_gap_cnt_next = GAP_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt - 4'd1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Loading drains the hold register into the shifter and starts a word.
    if (w_load) begin
      w_state_next     = ST_SHIFT;
      w_shift_next     = r_hold;
      w_bit_cnt_next   = '0;
      w_hold_full_next = 1'b0;
    end

    // Acceptance needs an empty hold register, so it never collides with a load.
    if (w_accept) begin
      w_hold_next      = in_data;
      w_hold_full_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: one instance with GAP=0 (a_*) and one with
// GAP=3 (b_*). Accepted words are expanded into a per-instance bit queue and
// compared bit by bit against the serial output; scenario tasks add inline
// timing and counter checks.
`timescale 1ns/1ps
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_in_data, b_in_data;
  logic       a_in_valid, b_in_valid;
  logic       a_in_ready, b_in_ready;
  logic       a_bit_out, b_bit_out;
  logic       a_bit_valid, b_bit_valid;
  logic       a_frame_start, b_frame_start;
  logic [7:0] a_sent_cnt, b_sent_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {frame_start expected, bit expected}
  logic [1:0] sb_a[$];
  logic [1:0] sb_b[$];
  logic [1:0] exp_a, exp_b;

  always #5 clk = ~clk;

  serial_bit_feeder #(.DATA_W(8), .GAP(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
    .frame_start(a_frame_start), .sent_cnt(a_sent_cnt)
  );

  serial_bit_feeder #(.DATA_W(8), .GAP(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .bit_out(b_bit_out), .bit_valid(b_bit_valid),
    .frame_start(b_frame_start), .sent_cnt(b_sent_cnt)
  );

  // Monitor / scoreboard for instance a
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_a.delete();
    end else begin
      n_checks++;
      if (a_bit_valid) begin
        if (sb_a.size() == 0) begin
          n_errors++;
          $display("FAIL a_unexpected_bit: bit_out=%0b while no word pending", a_bit_out);
        end else begin
          exp_a = sb_a.pop_front();
          if ({a_frame_start, a_bit_out} !== exp_a) begin
            n_errors++;
            $display("FAIL a_bit: got frame_start/bit=%b required %b", {a_frame_start, a_bit_out}, exp_a);
          end
        end
      end else if (a_bit_out !== 1'b0 || a_frame_start !== 1'b0) begin
        n_errors++;
        $display("FAIL a_idle_out: got bit_out=%0b frame_start=%0b required 0/0", a_bit_out, a_frame_start);
      end
      if (a_in_valid && a_in_ready) begin
        $display("a: accepted word 0x%02h", a_in_data);
        for (int i = 7; i >= 0; i--) sb_a.push_back({(i == 7), a_in_data[i]});
      end
    end
  end

  // Monitor / scoreboard for instance b
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_b.delete();
    end else begin
      n_checks++;
      if (b_bit_valid) begin
        if (sb_b.size() == 0) begin
          n_errors++;
          $display("FAIL b_unexpected_bit: bit_out=%0b while no word pending", b_bit_out);
        end else begin
          exp_b = sb_b.pop_front();
          if ({b_frame_start, b_bit_out} !== exp_b) begin
            n_errors++;
            $display("FAIL b_bit: got frame_start/bit=%b required %b", {b_frame_start, b_bit_out}, exp_b);
          end
        end
      end else if (b_bit_out !== 1'b0 || b_frame_start !== 1'b0) begin
        n_errors++;
        $display("FAIL b_idle_out: got bit_out=%0b frame_start=%0b required 0/0", b_bit_out, b_frame_start);
      end
      if (b_in_valid && b_in_ready) begin
        $display("b: accepted word 0x%02h", b_in_data);
        for (int i = 7; i >= 0; i--) sb_b.push_back({(i == 7), b_in_data[i]});
      end
    end
  end

  // Present a word on a and return #1 after the edge that accepts it; in_valid stays high.
  task automatic push_a(input logic [7:0] d);
    bit rdy;
    bit done;
    done = 1'b0;
    a_in_data  = d;
    a_in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      rdy = a_in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL a_push_timeout: word 0x%02h accepted=0 required 1", d);
    end
  endtask

  task automatic push_b(input logic [7:0] d);
    bit rdy;
    bit done;
    done = 1'b0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      rdy = b_in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL b_push_timeout: word 0x%02h accepted=0 required 1", d);
    end
  endtask

  // Wait until instance a is idle with an empty hold register.
  task automatic wait_idle_a();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      if (a_in_ready && !a_bit_valid) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL a_idle_timeout: idle=0 required 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00;
    b_in_valid = 1'b0; b_in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a_in_ready, a_bit_out, a_bit_valid, a_frame_start, a_sent_cnt} !== {4'b1000, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_a: got rdy/bit/valid/fs/cnt=%b required %b",
               {a_in_ready, a_bit_out, a_bit_valid, a_frame_start, a_sent_cnt}, {4'b1000, 8'd0});
    end
    n_checks++;
    if ({b_in_ready, b_bit_out, b_bit_valid, b_frame_start, b_sent_cnt} !== {4'b1000, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_b: got rdy/bit/valid/fs/cnt=%b required %b",
               {b_in_ready, b_bit_out, b_bit_valid, b_frame_start, b_sent_cnt}, {4'b1000, 8'd0});
    end
    rst_n = 1'b1;
  endtask

  // 0xA5 from IDLE: capture edge, load edge, then 8 bits MSB first.
  task automatic test_a5();
    logic [7:0] w;
    w = 8'hA5;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL a5_ready_after_reset: got %0b required 1", a_in_ready);
    end
    a_in_data = w; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = 8'h00;
    n_checks++;
    if (a_in_ready !== 1'b0 || a_bit_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL a5_capture: got ready=%0b bit_valid=%0b required 0/0", a_in_ready, a_bit_valid);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (a_bit_valid !== 1'b1 || a_bit_out !== w[7-i] || a_frame_start !== (i == 0)) begin
        n_errors++;
        $display("FAIL a5_bit%0d: got valid/bit/fs=%0b%0b%0b required 1%0b%0b",
                 i, a_bit_valid, a_bit_out, a_frame_start, w[7-i], (i == 0));
      end
      if (i == 7) begin
        n_checks++;
        if (a_sent_cnt !== 8'd0) begin
          n_errors++;
          $display("FAIL a5_cnt_early: got %0d required 0", a_sent_cnt);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_bit_valid !== 1'b0 || a_sent_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL a5_done: got valid=%0b sent_cnt=%0d required 0/1", a_bit_valid, a_sent_cnt);
    end
  endtask

  // 0xFF then 0x00 with valid held: 16 contiguous bits, frame_start on 1st and 9th.
  task automatic test_back_to_back();
    a_in_data = 8'hFF; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_data = 8'h00;
    n_checks++;
    if (a_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_hold_full: got ready=%0b required 0", a_in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready_after_load: got ready=%0b required 1", a_in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (a_bit_valid !== 1'b1 || a_bit_out !== (i < 8) || a_frame_start !== (i == 0 || i == 8)) begin
        n_errors++;
        $display("FAIL b2b_bit%0d: got valid/bit/fs=%0b%0b%0b required 1%0b%0b",
                 i, a_bit_valid, a_bit_out, a_frame_start, (i < 8), (i == 0 || i == 8));
      end
      @(posedge clk); #1;
      if (i == 0) a_in_valid = 1'b0;
    end
    n_checks++;
    if (a_bit_valid !== 1'b0 || a_sent_cnt !== 8'd3) begin
      n_errors++;
      $display("FAIL b2b_done: got valid=%0b sent_cnt=%0d required 0/3", a_bit_valid, a_sent_cnt);
    end
  endtask

  // GAP=3 instance: two 0x81 words separated by exactly 3 idle cycles.
  task automatic test_gap();
    logic v[40];
    logic o[40];
    int r1, z, r2, k;
    bit gap_bad;
    r1 = 0; z = 0; r2 = 0; k = 0; gap_bad = 1'b0;
    push_b(8'h81);
    push_b(8'h81);
    b_in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v[i] = b_bit_valid;
      o[i] = b_bit_out;
      @(posedge clk); #1;
    end
    while (k < 40 && v[k]) begin r1++; k++; end
    while (k < 40 && !v[k]) begin
      if (o[k]) gap_bad = 1'b1;
      z++; k++;
    end
    while (k < 40 && v[k]) begin r2++; k++; end
    n_checks++;
    if (r1 != 7 || z != 3 || r2 != 8 || gap_bad) begin
      n_errors++;
      $display("FAIL gap_shape: got run1=%0d gap=%0d run2=%0d gap_bit1=%0b required 7/3/8/0", r1, z, r2, gap_bad);
    end
    n_checks++;
    if (b_sent_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL gap_cnt: got %0d required 2", b_sent_cnt);
    end
  endtask

  // Three distinct words with valid held; in_ready low right after each capture.
  task automatic test_hold();
    logic [7:0] words [3];
    words[0] = 8'h3C; words[1] = 8'h5A; words[2] = 8'hE7;
    for (int i = 0; i < 3; i++) begin
      push_a(words[i]);
      n_checks++;
      if (a_in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_ready_w%0d: got %0b required 0", i, a_in_ready);
      end
    end
    a_in_valid = 1'b0;
    wait_idle_a();
    n_checks++;
    if (a_sent_cnt !== 8'd6 || sb_a.size() != 0) begin
      n_errors++;
      $display("FAIL hold_done: got sent_cnt=%0d pending_bits=%0d required 6/0", a_sent_cnt, sb_a.size());
    end
  endtask

  // Reset after 3 bits of 0xC3 with a second word held; nothing more must emerge.
  task automatic test_reset_mid();
    push_a(8'hC3);
    push_a(8'h77);
    a_in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (a_bit_valid !== 1'b1 || a_sent_cnt !== 8'd6) begin
      n_errors++;
      $display("FAIL rmid_pre: got valid=%0b sent_cnt=%0d required 1/6", a_bit_valid, a_sent_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_in_ready, a_bit_out, a_bit_valid, a_frame_start, a_sent_cnt} !== {4'b1000, 8'd0}) begin
      n_errors++;
      $display("FAIL rmid_reset: got rdy/bit/valid/fs/cnt=%b required %b",
               {a_in_ready, a_bit_out, a_bit_valid, a_frame_start, a_sent_cnt}, {4'b1000, 8'd0});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (a_bit_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rmid_leftover%0d: got bit_valid=%0b required 0", i, a_bit_valid);
      end
    end
    push_a(8'h01);
    a_in_valid = 1'b0;
    wait_idle_a();
    n_checks++;
    if (a_sent_cnt !== 8'd1 || b_sent_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL rmid_after: got a_cnt=%0d b_cnt=%0d required 1/0", a_sent_cnt, b_sent_cnt);
    end
  endtask

  // 257 words from a fresh reset: sent_cnt 255, then wraps to 0, then 1.
  task automatic test_wrap();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 255; i++) push_a(8'($urandom));
    a_in_valid = 1'b0;
    wait_idle_a();
    n_checks++;
    if (a_sent_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL wrap_255: got %0d required 255", a_sent_cnt);
    end
    push_a(8'($urandom));
    a_in_valid = 1'b0;
    wait_idle_a();
    n_checks++;
    if (a_sent_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL wrap_256: got %0d required 0", a_sent_cnt);
    end
    push_a(8'($urandom));
    a_in_valid = 1'b0;
    wait_idle_a();
    n_checks++;
    if (a_sent_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL wrap_257: got %0d required 1", a_sent_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_gap();
    test_hold();
    test_reset_mid();
    test_wrap();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      n_errors++;
      $display("FAIL end_pending: got a=%0d b=%0d bits required 0/0", sb_a.size(), sb_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
